// File: rtl/period_divider.sv
// Sequential restoring divider: freq_out = DIVIDEND / period_in, one quotient bit per clock.
// Define PERIOD_DIV_ROUND_EN to add a round-half-up stage (saturating) after the divide loop.
module period_divider #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DIVIDEND = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] period_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] freq_out,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PERIOD_DIV_ROUND_EN
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t state, state_n;

    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH:0]   rem, rem_n, rem_sh;
    logic [CW-1:0]    cnt;
    logic             zero_flag;
    logic             last_iter;

    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (period_in == '0) ? DONE : CALC;
`ifdef PERIOD_DIV_ROUND_EN
            CALC:  if (last_iter) state_n = ROUND;
            ROUND: state_n = DONE;
`else
            CALC:  if (last_iter) state_n = DONE;
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        case (state)
            CALC: busy = 1'b1;
`ifdef PERIOD_DIV_ROUND_EN
            ROUND: busy = 1'b1;
`endif
            DONE: begin
                done     = 1'b1;
                div_zero = zero_flag;
            end
            default: ;
        endcase
    end

    // One restoring step: shift the quotient MSB into the remainder, trial-subtract.
    always_comb begin
        rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_n  = rem_sh;
        quo_n  = {quo[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, divisor}) begin
            rem_n    = rem_sh - {1'b0, divisor};
            quo_n[0] = 1'b1;
        end
    end

`ifdef PERIOD_DIV_ROUND_EN
    logic [WIDTH-1:0] quo_rnd;
    always_comb begin
        quo_rnd = quo;
        if (({rem, 1'b0} >= {2'b00, divisor}) && !(&quo))
            quo_rnd = quo + WIDTH'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
            freq_out  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (period_in != '0) begin
                        divisor   <= period_in;
                        quo       <= WIDTH'(DIVIDEND);
                        rem       <= '0;
                        cnt       <= '0;
                        zero_flag <= 1'b0;
                    end else begin
                        zero_flag <= 1'b1;
                    end
                end
                CALC: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + CW'(1);
`ifndef PERIOD_DIV_ROUND_EN
                    // Final quotient is written on the same edge that enters DONE.
                    if (last_iter) freq_out <= quo_n;
`endif
                end
`ifdef PERIOD_DIV_ROUND_EN
                ROUND: freq_out <= quo_rnd;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_period_divider.sv
// Scoreboard bench for period_divider: expected results queued at start, checked on done.
module tb_period_divider;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DIVIDEND = 50_000_000;
`ifdef PERIOD_DIV_ROUND_EN
    localparam int unsigned LAT    = WIDTH + 2;
    localparam int unsigned BUSY_N = WIDTH + 1;
`else
    localparam int unsigned LAT    = WIDTH + 1;
    localparam int unsigned BUSY_N = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] period_in = '0;
    logic             start = 1'b0;
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] freq_out;

    typedef struct {
        longint unsigned freq;
        logic            zero;
        int              lat;
        int              busy_n;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad   = 0;
    longint unsigned last_freq = 0;

    period_divider #(.WIDTH(WIDTH), .DIVIDEND(DIVIDEND)) dut (
        .clk(clk), .rst(rst), .period_in(period_in), .start(start),
        .busy(busy), .done(done), .freq_out(freq_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned model(input longint unsigned p);
        longint unsigned q, r;
        q = longint'(DIVIDEND) / p;
        r = longint'(DIVIDEND) % p;
`ifdef PERIOD_DIV_ROUND_EN
        if (2 * r >= p && q != 64'hFFFF_FFFF) q = q + 1;
`endif
        return q;
    endfunction

    // Drive start for the cycle ending at the accept edge and queue the expectation.
    task automatic issue(input longint unsigned p);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        period_in = WIDTH'(p);
        if (p == 0) begin
            e.freq = last_freq; e.zero = 1'b1; e.lat = 1; e.busy_n = 0;
        end else begin
            e.freq = model(p); e.zero = 1'b0; e.lat = LAT; e.busy_n = BUSY_N;
        end
        sb.push_back(e);
    endtask

    // Counts negedges after the accept edge; a second start may be thrown at cycle 'second_at'.
    task automatic wait_done(input string tag, input int second_at, input longint unsigned p2);
        int   n = 0;
        int   bn = 0;
        exp_t e;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start     = 1'b0;
                period_in = $urandom;
            end
            if (second_at != 0 && n == second_at) begin
                start = 1'b1; period_in = WIDTH'(p2);
            end
            if (second_at != 0 && n == second_at + 1) start = 1'b0;
            if (busy) bn++;
        end
        start = 1'b0;
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_freq"}, freq_out, e.freq);
        chk({tag, "_div_zero"}, div_zero, e.zero);
        chk({tag, "_busy_cycles"}, bn, e.busy_n);
        last_freq = e.freq;
    endtask

    task automatic quiet(input string tag, input int cycles);
        int extra = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({tag, "_no_extra_done"}, extra, 0);
    endtask

    task automatic run(input string tag, input longint unsigned p);
        issue(p);
        wait_done(tag, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_freq", freq_out, 0);
        rst = 1'b0;
        @(negedge clk);

        run("p1000", 1000);
        run("p1", 1);
        run("p1000b", 1000);
        run("p0", 0);
        quiet("p0", 5);
        run("p3", 3);
        run("p7", 7);
        run("p50M", 50_000_000);
        run("p50M1", 50_000_001);
        run("pmax", 64'hFFFF_FFFF);

        // Second start while busy must be dropped, not queued.
        issue(1000);
        wait_done("rej", 10, 2);
        quiet("rej", 50);

        // Reset ten cycles into CALC aborts the divide at once.
        issue(1000);
        repeat (10) @(negedge clk) start = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_freq", freq_out, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        last_freq = 0;
        quiet("mid_rst", 50);
        run("p500", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
